// File: rtl/path_executor.sv
// path_executor: walks a solved one-hot move list from START to GOAL over a valid/ready handshake.
// Optional macro PATH_EXECUTOR_CHECK_EN enables direction, bounds, wall and final-goal checks.
module path_executor #(
    parameter int N        = 10,
    parameter int MAX_LEN  = 99,
    parameter int START_R  = 9,
    parameter int START_C  = 0,
    parameter int GOAL_R   = 0,
    parameter int GOAL_C   = 9,
    parameter int STEP_GAP = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       maze [0:N*N-1],
    input  logic [3:0] path [0:MAX_LEN-1],
    input  logic [6:0] path_length,
    input  logic       path_ready,
    input  logic       no_path,
    output logic       move_valid,
    input  logic       move_ready,
    output logic [3:0] move_dir,
    output logic [3:0] cur_row,
    output logic [3:0] cur_col,
    output logic [6:0] step_idx,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_EMIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [1:0] ERR_BADDIR = 2'd0;
    localparam logic [1:0] ERR_BOUNDS = 2'd1;
    localparam logic [1:0] ERR_WALL   = 2'd2;
    localparam logic [1:0] ERR_NOPATH = 2'd3;

    state_t      state_r;
    logic [6:0]  len_r;
    logic [6:0]  step_idx_r;
    logic [3:0]  cur_row_r;
    logic [3:0]  cur_col_r;
    logic [3:0]  move_dir_r;
    logic        move_valid_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic [1:0]  err_code_r;
    logic [15:0] gap_cnt_r;

    logic [3:0]  dir_s;
    logic [4:0]  row_nxt_s;
    logic [4:0]  col_nxt_s;
    logic        at_goal_s;

    assign move_valid = move_valid_r;
    assign move_dir   = move_dir_r;
    assign cur_row    = cur_row_r;
    assign cur_col    = cur_col_r;
    assign step_idx   = step_idx_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign err_code   = err_code_r;

    // Decode the pending move; next position is 5-bit so stepping below 0 shows up as a large value.
    always_comb begin
        dir_s     = (step_idx_r < 7'(MAX_LEN)) ? path[step_idx_r] : 4'd0;
        row_nxt_s = {1'b0, cur_row_r} + {4'd0, dir_s[1]} - {4'd0, dir_s[0]};
        col_nxt_s = {1'b0, cur_col_r} + {4'd0, dir_s[3]} - {4'd0, dir_s[2]};
        at_goal_s = (cur_row_r == 4'(GOAL_R)) && (cur_col_r == 4'(GOAL_C));
    end

`ifdef PATH_EXECUTOR_CHECK_EN
    localparam int IW = $clog2(N*N);

    logic          in_bounds_s;
    logic          wall_s;
    logic [IW-1:0] maze_idx_s;

    function automatic logic is_onehot4(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

    // Target cell legality: inside the grid and not a wall.
    always_comb begin
        in_bounds_s = (row_nxt_s < 5'(N)) && (col_nxt_s < 5'(N));
        maze_idx_s  = IW'(row_nxt_s) * IW'(N) + IW'(col_nxt_s);
        wall_s      = in_bounds_s ? maze[maze_idx_s] : 1'b0;
    end
`else
    logic chk_unused_s;

    // Checks are compiled out; fold otherwise-unread inputs into a sink.
    always_comb begin
        chk_unused_s = at_goal_s ^ row_nxt_s[4] ^ col_nxt_s[4];
        for (int i = 0; i < N*N; i++) begin
            chk_unused_s = chk_unused_s ^ maze[i];
        end
    end
`endif

    // Walk controller with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            len_r        <= 7'd0;
            step_idx_r   <= 7'd0;
            cur_row_r    <= 4'(START_R);
            cur_col_r    <= 4'(START_C);
            move_dir_r   <= 4'd0;
            move_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            err_code_r   <= 2'd0;
            gap_cnt_r    <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (path_ready) begin
                        step_idx_r <= 7'd0;
                        cur_row_r  <= 4'(START_R);
                        cur_col_r  <= 4'(START_C);
                        if (path_length > 7'(MAX_LEN)) begin
                            err_r      <= 1'b1;
                            err_code_r <= ERR_NOPATH;
                            state_r    <= ST_ERR;
                        end else begin
                            len_r   <= path_length;
                            busy_r  <= 1'b1;
                            state_r <= ST_CHECK;
                        end
                    end else if (no_path) begin
                        err_r      <= 1'b1;
                        err_code_r <= ERR_NOPATH;
                        state_r    <= ST_ERR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (step_idx_r == len_r) begin
                        busy_r <= 1'b0;
`ifdef PATH_EXECUTOR_CHECK_EN
                        if (at_goal_s) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            err_r      <= 1'b1;
                            err_code_r <= ERR_NOPATH;
                            state_r    <= ST_ERR;
                        end
`else
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
`endif
                    end
`ifdef PATH_EXECUTOR_CHECK_EN
                    else if (!is_onehot4(dir_s)) begin
                        busy_r     <= 1'b0;
                        err_r      <= 1'b1;
                        err_code_r <= ERR_BADDIR;
                        state_r    <= ST_ERR;
                    end else if (!in_bounds_s) begin
                        busy_r     <= 1'b0;
                        err_r      <= 1'b1;
                        err_code_r <= ERR_BOUNDS;
                        state_r    <= ST_ERR;
                    end else if (wall_s) begin
                        busy_r     <= 1'b0;
                        err_r      <= 1'b1;
                        err_code_r <= ERR_WALL;
                        state_r    <= ST_ERR;
                    end
`endif
                    else begin
                        move_dir_r   <= dir_s;
                        move_valid_r <= 1'b1;
                        state_r      <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    // path is stable while busy, so dir_s still matches the move on offer.
                    if (move_ready) begin
                        move_valid_r <= 1'b0;
                        cur_row_r    <= row_nxt_s[3:0];
                        cur_col_r    <= col_nxt_s[3:0];
                        step_idx_r   <= step_idx_r + 7'd1;
                        gap_cnt_r    <= 16'd0;
                        state_r      <= (STEP_GAP > 0) ? ST_GAP : ST_CHECK;
                    end else begin
                        state_r <= ST_EMIT;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 16'(STEP_GAP - 1)) begin
                        state_r <= ST_CHECK;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 16'd1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    // Require one edge of quiet status so a held level cannot restart the walk.
                    if (!path_ready && !no_path) begin
                        done_r  <= 1'b0;
                        err_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    move_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                    err_r        <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_executor.sv
// Directed bench for path_executor; expectations follow PATH_EXECUTOR_CHECK_EN when defined.
module tb_path_executor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       maze [0:99];
    logic [3:0] path [0:98];
    logic [6:0] path_length;
    logic       path_ready;
    logic       no_path;
    logic       move_valid;
    logic       move_ready;
    logic [3:0] move_dir;
    logic [3:0] cur_row;
    logic [3:0] cur_col;
    logic [6:0] step_idx;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;
    int exp_n    = 0;
    logic [3:0] exp_dir [0:98];

`ifdef PATH_EXECUTOR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [3:0] UP    = 4'b0001;
    localparam logic [3:0] LEFT  = 4'b0100;
    localparam logic [3:0] RIGHT = 4'b1000;

    always #5 clk = ~clk;

    path_executor dut (
        .clk(clk), .rst_n(rst_n), .maze(maze), .path(path),
        .path_length(path_length), .path_ready(path_ready), .no_path(no_path),
        .move_valid(move_valid), .move_ready(move_ready), .move_dir(move_dir),
        .cur_row(cur_row), .cur_col(cur_col), .step_idx(step_idx),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 100; i++) maze[i] = 1'b0;
        for (int i = 0; i < 99; i++) begin
            path[i]    = 4'd0;
            exp_dir[i] = 4'd0;
        end
        path_length = 7'd0;
        path_ready  = 1'b0;
        no_path     = 1'b0;
        move_ready  = 1'b0;
        exp_n       = 0;
    endtask

    task automatic load_happy();
        for (int i = 0; i < 9; i++) begin
            path[i]        = UP;
            path[i + 9]    = RIGHT;
            exp_dir[i]     = UP;
            exp_dir[i + 9] = RIGHT;
        end
        path_length = 7'd18;
        exp_n       = 18;
    endtask

    task automatic release_status();
        path_ready = 1'b0;
        no_path    = 1'b0;
        tick();
    endtask

    // Drives move_ready, counts handshakes, checks order and stability; stops at done/err or stop_at.
    task automatic run_walk(input int bp, input int stop_at);
        int   cyc;
        logic pend;
        logic [3:0] pdir;
        logic [7:0] ppos;
        cyc    = 0;
        pend   = 1'b0;
        pdir   = 4'd0;
        ppos   = 8'd0;
        hs_cnt = 0;
        while (!(done || err) && cyc < 2000 &&
               !(stop_at >= 0 && hs_cnt == stop_at && move_valid)) begin
            if (move_valid && pend) begin
                check_eq("dir_stable", 32'(move_dir), 32'(pdir));
                check_eq("pos_stable", 32'({cur_row, cur_col}), 32'(ppos));
            end
            move_ready = (bp != 0) ? (cyc % 3 == 0) : 1'b1;
            if (move_valid && move_ready) begin
                if (hs_cnt < exp_n) check_eq("dir_order", 32'(move_dir), 32'(exp_dir[hs_cnt]));
                hs_cnt++;
            end
            pend = move_valid && !move_ready;
            pdir = move_dir;
            ppos = {cur_row, cur_col};
            tick();
            cyc++;
        end
        if (stop_at < 0) check_eq("walk_end", 32'(done | err), 32'd1);
        else             check_eq("stop_reached", 32'(move_valid), 32'd1);
        check_eq("done_err_excl", 32'(done & err), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check_eq("rst_valid_async", 32'(move_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rst_state", 32'({busy, done, err, move_valid}), 32'd0);
        check_eq("rst_pos", 32'({cur_row, cur_col}), 32'h90);
        check_eq("rst_step", 32'(step_idx), 32'd0);
        check_eq("rst_dir_code", 32'({move_dir, err_code}), 32'd0);

        // Happy path with latency and retrigger checks.
        load_happy();
        move_ready = 1'b1;
        path_ready = 1'b1;
        tick();
        check_eq("lat_check_valid", 32'(move_valid), 32'd0);
        check_eq("lat_check_busy", 32'(busy), 32'd1);
        tick();
        check_eq("lat_first_valid", 32'(move_valid), 32'd1);
        run_walk(0, -1);
        check_eq("happy_hs", 32'(hs_cnt), 32'd18);
        check_eq("happy_done", 32'({done, err, busy, move_valid}), 32'b1000);
        check_eq("happy_pos", 32'({cur_row, cur_col}), 32'h09);
        check_eq("happy_step", 32'(step_idx), 32'd18);
        tick();
        tick();
        tick();
        check_eq("retrig_hold_done", 32'(done), 32'd1);
        check_eq("retrig_hold_step", 32'(step_idx), 32'd18);
        release_status();
        check_eq("retrig_exit", 32'({done, busy}), 32'd0);

        // Backpressure: same path, ready high 1 of 3 cycles.
        move_ready = 1'b0;
        path_ready = 1'b1;
        run_walk(1, -1);
        check_eq("bp_hs", 32'(hs_cnt), 32'd18);
        check_eq("bp_done", 32'(done), 32'd1);
        check_eq("bp_pos", 32'({cur_row, cur_col}), 32'h09);
        release_status();

        // Wall directly above start.
        maze[80]   = 1'b1;
        path_ready = 1'b1;
        run_walk(0, -1);
        check_eq("wall_hs", 32'(hs_cnt), CHK ? 32'd0 : 32'd18);
        check_eq("wall_err", 32'({err, done}), CHK ? 32'b10 : 32'b01);
        check_eq("wall_code", 32'(err_code), CHK ? 32'd2 : 32'd0);
        check_eq("wall_pos", 32'({cur_row, cur_col}), CHK ? 32'h90 : 32'h09);
        release_status();
        maze[80] = 1'b0;

        // Off the left edge.
        path[0]     = LEFT;
        exp_dir[0]  = LEFT;
        path_length = 7'd1;
        exp_n       = 1;
        path_ready  = 1'b1;
        run_walk(0, -1);
        check_eq("bounds_hs", 32'(hs_cnt), CHK ? 32'd0 : 32'd1);
        check_eq("bounds_err", 32'({err, done}), CHK ? 32'b10 : 32'b01);
        check_eq("bounds_code", 32'(err_code), CHK ? 32'd1 : 32'd0);
        check_eq("bounds_pos", 32'({cur_row, cur_col}), CHK ? 32'h90 : 32'h9F);
        release_status();

        // Not one-hot.
        path[0]    = 4'b0011;
        exp_dir[0] = 4'b0011;
        path_ready = 1'b1;
        run_walk(0, -1);
        check_eq("baddir_hs", 32'(hs_cnt), CHK ? 32'd0 : 32'd1);
        check_eq("baddir_err", 32'({err, done}), CHK ? 32'b10 : 32'b01);
        check_eq("baddir_code", 32'(err_code), 32'd0);
        check_eq("baddir_step", 32'(step_idx), CHK ? 32'd0 : 32'd1);
        release_status();

        // Solver failure: one edge to ERR, held while status stays high.
        no_path = 1'b1;
        tick();
        check_eq("nopath_err", 32'({err, done, busy}), 32'b100);
        check_eq("nopath_code", 32'(err_code), 32'd3);
        tick();
        tick();
        check_eq("nopath_hold", 32'(err), 32'd1);
        release_status();
        check_eq("nopath_exit", 32'(err), 32'd0);

        // Overlong length aborts immediately.
        path_length = 7'd100;
        path_ready  = 1'b1;
        tick();
        check_eq("overlong_err", 32'({err, busy, move_valid}), 32'b100);
        release_status();

        // Short path ending at (6,0).
        for (int i = 0; i < 3; i++) begin
            path[i]    = UP;
            exp_dir[i] = UP;
        end
        path_length = 7'd3;
        exp_n       = 3;
        path_ready  = 1'b1;
        run_walk(0, -1);
        check_eq("short_hs", 32'(hs_cnt), 32'd3);
        check_eq("short_pos", 32'({cur_row, cur_col}), 32'h60);
        check_eq("short_err", 32'({err, done}), CHK ? 32'b10 : 32'b01);
        check_eq("short_code", 32'(err_code), 32'd3);
        release_status();

        // Both status levels high: path_ready wins.
        load_happy();
        path_ready = 1'b1;
        no_path    = 1'b1;
        tick();
        check_eq("prio_busy", 32'({busy, err}), 32'b10);
        no_path = 1'b0;
        run_walk(0, -1);
        check_eq("prio_done", 32'(done), 32'd1);
        release_status();

        // Reset while move 5 is on offer, then a fresh walk.
        path_ready = 1'b1;
        run_walk(0, 5);
        check_eq("midrst_dir", 32'(move_dir), 32'(UP));
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'({move_valid, busy}), 32'd0);
        check_eq("midrst_pos", 32'({cur_row, cur_col}), 32'h90);
        check_eq("midrst_step", 32'(step_idx), 32'd0);
        path_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        path_ready = 1'b1;
        run_walk(0, -1);
        check_eq("restart_hs", 32'(hs_cnt), 32'd18);
        check_eq("restart_pos", 32'({cur_row, cur_col}), 32'h09);
        check_eq("restart_done", 32'(done), 32'd1);
        release_status();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
